unified_memory: RTL and testbench

Unified instruction/data memory for the multi-cycle MIPS core. It sits directly downstream of the processor's memory port, which is the IorD-selected address, WriteData and MemWrite. It serves one word-aligned read or write at a time over a req/ready handshake with a parameterised wait-state count, so the controller can be extended to stall on memory. Misaligned or out-of-range accesses complete with an error flag and have no side effects.

---
 rtl/unified_memory_pkg.sv | 27 ++
 rtl/unified_memory_if.sv | 26 ++
 rtl/unified_memory_spram.sv | 27 ++
 rtl/unified_memory.sv | 132 +++++++++++++
 tb/tb_unified_memory.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/unified_memory_pkg.sv
// Shared types and constants for the unified instruction/data memory.
// Holds the FSM state encoding, word/counter widths and the address check helper.
// Imported by the interface, the RAM and the top-level controller.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  // Low address bits that must be zero for a word-aligned access
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when a byte address is misaligned or beyond a 2**aw word array
  function automatic logic addr_bad(input logic [WORD_W-1:0] a, input int aw);
    logic misaligned;
    logic out_of_range;
    misaligned   = |(a & ALIGN_MASK);
    out_of_range = (a >> (aw + 2)) != '0;
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/unified_memory_if.sv
// Request/response bundle between the processor memory port and the memory.
// The master drives req/we/addr/wdata; the memory answers with a one-cycle ready.
// busy tells the master that req is currently being ignored.
interface unified_memory_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/unified_memory_spram.sv
// Single-port word RAM: synchronous write, combinational read.
// The array is never reset so contents survive a controller reset.
// No handshake; the controller decides when a write is allowed.
module spram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  // Commit a word on the clock edge when enabled
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/unified_memory.sv
// Unified memory controller: one aligned word read/write at a time over req/ready.
// Response arrives LATENCY+1 cycles after accept; ready is a one-cycle strobe.
// Requests are ignored while busy; bad addresses answer with err and no side effects.
module unified_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               reset,
  unified_memory_if.slave    bus
);

  // Counter preload so that WAIT lasts exactly LATENCY cycles
  localparam logic [LAT_W-1:0] LAT_INIT = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  // The transaction in progress: live inputs on the accept cycle, latches afterwards.
  // This matters for LATENCY=0, where the accept edge is also the edge entering RESP.
  logic              cur_we;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_bad;
  logic              enter_resp;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign cur_we    = (state_q == IDLE) ? bus.we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? bus.addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign cur_bad   = addr_bad(cur_addr, ADDR_WIDTH);

  // RESP is only ever entered from IDLE or WAIT, so this marks the entry edge
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  // Writes commit only on the edge entering RESP and never during reset
  assign ram_we     = enter_resp && cur_we && !cur_bad && !reset;

  spram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_spram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state, latency countdown and accept decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response data and error flag are captured on the edge entering RESP
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = cur_bad;
      if (cur_bad) begin
        rdata_d = '0;
      end else if (!cur_we) begin
        rdata_d = ram_rdata;
      end
    end
  end

  // State, counter, request latches and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && err_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_unified_memory.sv
// Directed bench for unified_memory: one instance at LATENCY=2, one at LATENCY=0.
// Inputs are driven and outputs sampled 1ns after the rising edge.
// Expected values are hand-computed constants.
module tb_unified_memory;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  unified_memory_if bus2 ();
  unified_memory_if bus0 ();

  unified_memory #(.ADDR_WIDTH(8), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  unified_memory #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full access on the LATENCY=2 instance, starting from IDLE and ending in IDLE
  task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    bus2.req   = 1'b1;
    bus2.we    = w;
    bus2.addr  = a;
    bus2.wdata = d;
    tick();
    bus2.req = 1'b0;
    lat = 1;
    while (!bus2.ready && lat < 20) begin
      tick();
      lat++;
    end
    rd = bus2.rdata;
    e  = bus2.err;
    tick();
  endtask

  // Single write on the LATENCY=0 instance
  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    bus0.req   = 1'b1;
    bus0.we    = 1'b1;
    bus0.addr  = a;
    bus0.wdata = d;
    tick();
    chk("lat0_wr_ready", {31'd0, bus0.ready}, 32'd1);
    bus0.req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] exp_rd [3];

    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_flags", {29'd0, bus2.ready, bus2.err, bus2.busy}, 32'd0);
      chk("idle_rdata", bus2.rdata, 32'd0);
    end

    // Write 0xDEADBEEF to 0x10 with cycle-exact timing, then back-to-back read
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h10; bus2.wdata = 32'hDEADBEEF;
    tick();
    bus2.req = 1'b0;
    chk("wr_n1_busy_ready", {30'd0, bus2.busy, bus2.ready}, 32'b10);
    tick();
    chk("wr_n2_busy_ready", {30'd0, bus2.busy, bus2.ready}, 32'b10);
    tick();
    chk("wr_n3_busy_ready_err", {29'd0, bus2.busy, bus2.ready, bus2.err}, 32'b110);
    bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 32'h10; bus2.wdata = 32'h0;
    tick();
    chk("rd_idle_busy_ready", {30'd0, bus2.busy, bus2.ready}, 32'b00);
    tick();
    bus2.req = 1'b0;
    chk("rd_n1_busy", {31'd0, bus2.busy}, 32'd1);
    tick();
    tick();
    chk("rd_ready", {31'd0, bus2.ready}, 32'd1);
    chk("rd_data", bus2.rdata, 32'hDEADBEEF);
    tick();

    // LATENCY=0: preload three words, then reads with req held high
    wr0(32'h0, 32'h0000_0100);
    wr0(32'h4, 32'h0000_0104);
    wr0(32'h8, 32'h0000_0108);
    exp_rd[0] = 32'h0000_0100;
    exp_rd[1] = 32'h0000_0104;
    exp_rd[2] = 32'h0000_0108;
    bus0.req = 1'b1; bus0.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.addr = 32'(i * 4);
      tick();
      chk("lat0_rd_ready", {31'd0, bus0.ready}, 32'd1);
      chk("lat0_rd_data", bus0.rdata, exp_rd[i]);
      tick();
      chk("lat0_gap_ready", {31'd0, bus0.ready}, 32'd0);
    end
    bus0.req = 1'b0;

    // Error responses: misaligned write and out-of-range accesses
    acc2(1'b1, 32'h4, 32'h1111_2222, rd, e, lat);
    acc2(1'b1, 32'h0, 32'hA5A5_A5A5, rd, e, lat);
    acc2(1'b1, 32'h6, 32'hFFFF_FFFF, rd, e, lat);
    chk("mis_lat", 32'(lat), 32'd3);
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    acc2(1'b0, 32'h4, 32'h0, rd, e, lat);
    chk("mis_word4_err", {31'd0, e}, 32'd0);
    chk("mis_word4", rd, 32'h1111_2222);
    acc2(1'b0, 32'h400, 32'h0, rd, e, lat);
    chk("oor_rd_lat", 32'(lat), 32'd3);
    chk("oor_rd_err", {31'd0, e}, 32'd1);
    chk("oor_rd_rdata", rd, 32'd0);
    acc2(1'b1, 32'h400, 32'h0000_0BAD, rd, e, lat);
    chk("oor_wr_err", {31'd0, e}, 32'd1);
    acc2(1'b0, 32'h0, 32'h0, rd, e, lat);
    chk("oor_word0", rd, 32'hA5A5_A5A5);
    chk("after_err_flag", {31'd0, bus2.err}, 32'd0);

    // Inputs changing during WAIT must not affect the latched write
    acc2(1'b1, 32'h24, 32'h2424_2424, rd, e, lat);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h20; bus2.wdata = 32'hCAFE_F00D;
    tick();
    bus2.req = 1'b0; bus2.addr = 32'h24; bus2.wdata = 32'h0BAD_F00D;
    lat = 1;
    while (!bus2.ready && lat < 20) begin
      tick();
      lat++;
    end
    chk("chg_lat", 32'(lat), 32'd3);
    tick();
    acc2(1'b0, 32'h20, 32'h0, rd, e, lat);
    chk("chg_word20", rd, 32'hCAFE_F00D);
    acc2(1'b0, 32'h24, 32'h0, rd, e, lat);
    chk("chg_word24", rd, 32'h2424_2424);

    // Reset during the first WAIT cycle of a write aborts it
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h10; bus2.wdata = 32'h1234_5678;
    tick();
    bus2.req = 1'b0;
    chk("rst_pre_busy", {31'd0, bus2.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_flags", {29'd0, bus2.ready, bus2.err, bus2.busy}, 32'd0);
    chk("rst_rdata", bus2.rdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    acc2(1'b0, 32'h10, 32'h0, rd, e, lat);
    chk("rst_word10", rd, 32'hDEADBEEF);
    chk("rst_word10_lat", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
